// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: configuration handshake and tick outputs of tick_scheduler
// Signals: cfg_valid/cfg_ready/cfg_ch/cfg_div form the divisor write handshake;
// tick and overrun are per-channel outputs; overrun_clr clears the sticky overrun bits;
// clock_out exists only when TICK_SCHED_SQUARE_EN is defined.
// Modports: master drives configuration (consumer/test side), slave is the scheduler.
interface tick_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 28
);
  localparam int CH_W = $clog2(NUM_CH);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] overrun;
  logic              overrun_clr;
`ifdef TICK_SCHED_SQUARE_EN
  logic [NUM_CH-1:0] clock_out;
  modport master (output cfg_valid, cfg_ch, cfg_div, overrun_clr,
                  input cfg_ready, tick, overrun, clock_out);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, overrun_clr,
                  output cfg_ready, tick, overrun, clock_out);
`else
  modport master (output cfg_valid, cfg_ch, cfg_div, overrun_clr,
                  input cfg_ready, tick, overrun);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, overrun_clr,
                  output cfg_ready, tick, overrun);
`endif
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler plus NUM_CH programmable divide channels, round-robin one-tick-per-cycle
// Ports: clock_in (posedge), reset_n (synchronous, active-low), bus (tick_scheduler_if.slave):
//   cfg_valid/cfg_ready/cfg_ch/cfg_div divisor writes (cfg_div=0 disables), tick one-hot registered,
//   overrun sticky per channel, overrun_clr clears it, clock_out 50% square per channel.
// Optional feature macro: TICK_SCHED_SQUARE_EN enables the clock_out square-wave outputs.
module tick_scheduler #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 28,
  parameter int               PRESCALE    = 1,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(100)
) (
  input  logic clock_in,
  input  logic reset_n,
  tick_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW   = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]                  pre_q, pre_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d, div_q, div_d;
  logic [NUM_CH-1:0]              en_q, en_d, pend_q, pend_d, tick_q, tick_d, ovr_q, ovr_d;
  logic [NUM_CH-1:0]              expire, req, cfg_mask;
  logic [CH_W-1:0]                rr_q, rr_d, gnt;
  logic                           base_tick, cfg_hit, found;
  assign bus.cfg_ready = reset_n;
  assign bus.tick      = tick_q;
  assign bus.overrun   = ovr_q;
  always_comb begin
    base_tick = pre_q == PW'(PRESCALE - 1);
    pre_d     = base_tick ? '0 : pre_q + PW'(1);
    // writes to a nonexistent channel are accepted but touch nothing
    cfg_hit   = bus.cfg_valid && bus.cfg_ready && (32'(bus.cfg_ch) < NUM_CH);
    cfg_mask  = cfg_hit ? NUM_CH'(1) << bus.cfg_ch : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // >= keeps a channel running after its divisor shrinks below the current count;
      // a same-cycle write to the channel suppresses its expiry entirely
      expire[i] = en_q[i] && base_tick && cnt_q[i] >= div_q[i] - CNT_W'(1) && !cfg_mask[i];
      cnt_d[i]  = (cfg_mask[i] || !en_q[i] || expire[i]) ? '0 :
                  base_tick ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      en_d[i]   = cfg_mask[i] ? |bus.cfg_div : en_q[i];
      div_d[i]  = (cfg_mask[i] && |bus.cfg_div) ? bus.cfg_div : div_q[i];
    end
    // a fresh expiry is eligible for grant in the cycle it happens
    req   = (pend_q | expire) & ~cfg_mask;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[(int'(rr_q) + k) % NUM_CH]) begin
        found = 1'b1;
        gnt   = CH_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
    tick_d = found ? NUM_CH'(1) << gnt : '0;
    pend_d = req & ~tick_d;
    // a new overrun beats a same-cycle clear
    ovr_d  = (ovr_q & ~{NUM_CH{bus.overrun_clr}}) | (expire & pend_q);
    rr_d   = found ? CH_W'((int'(gnt) + 1) % NUM_CH) : rr_q;
  end
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      div_q  <= {NUM_CH{DEFAULT_DIV}};
      en_q   <= '0;
      pend_q <= '0;
      tick_q <= '0;
      ovr_q  <= '0;
      rr_q   <= '0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      ovr_q  <= ovr_d;
      rr_q   <= rr_d;
    end
  end
`ifdef TICK_SCHED_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;
  assign bus.clock_out = sq_q;
  // computed from next-state values so the registered output lines up with cnt_q
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) sq_d[i] = en_d[i] && cnt_d[i] < (div_d[i] >> 1);
  end
  always_ff @(posedge clock_in) begin
    if (!reset_n) sq_q <= '0;
    else sq_q <= sq_d;
  end
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed self-checking bench for tick_scheduler with an expected-tick scoreboard
module tb_tick_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  tick_scheduler_if #(.NUM_CH(4), .CNT_W(28)) bus();
  tick_scheduler_if #(.NUM_CH(4), .CNT_W(28)) b5();
  tick_scheduler #(.NUM_CH(4), .CNT_W(28), .PRESCALE(1)) dut (.clock_in(clk), .reset_n(reset_n), .bus(bus));
  tick_scheduler #(.NUM_CH(4), .CNT_W(28), .PRESCALE(5)) dut5 (.clock_in(clk), .reset_n(reset_n), .bus(b5));
  typedef struct {int cyc; logic [3:0] val;} exp_t;
  exp_t sb[$];
  int   t5[$];
  int   cyc = 0, n_pass = 0, n_chk = 0, base = 0, cnt = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic push(int c, logic [3:0] v);
    sb.push_back('{c, v});
  endtask
  task automatic run(int n);
    logic [3:0] e;
    for (int j = 0; j < n; j++) begin
      step();
      e = 4'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front().val;
      chk("tick", bus.tick, e);
    end
  endtask
  task automatic cfg(int ch, int dv);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = 28'(dv);
    run(1);
    bus.cfg_valid = 1'b0;
  endtask
  task automatic cfg5(int ch, int dv);
    b5.cfg_valid = 1'b1;
    b5.cfg_ch    = 2'(ch);
    b5.cfg_div   = 28'(dv);
    run(1);
    b5.cfg_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    for (int j = 0; j < 3; j++) begin
      run(1);
      chk("rst overrun", bus.overrun, 4'b0);
      chk("rst ready", bus.cfg_ready, 1'b0);
      chk("rst tick5", b5.tick, 4'b0);
    end
    reset_n = 1'b1;
    #1;
    chk("ready after rst", bus.cfg_ready, 1'b1);
  endtask
  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.overrun_clr = 1'b0;
    b5.cfg_valid  = 1'b0; b5.cfg_ch  = '0; b5.cfg_div  = '0; b5.overrun_clr  = 1'b0;
    do_reset();
    run(200);
    chk("idle overrun", bus.overrun, 4'b0);
    base = cyc + 1;
    for (int k = 1; k <= 6; k++) push(base + 4 * k, 4'b0001);
    cfg(0, 4);
    run(24);
    chk("single overrun", bus.overrun, 4'b0);
    chk("single sb empty", sb.size(), 0);
    do_reset();
    base = cyc + 1;
    for (int n = 2; n <= 14; n++) push(base + n, 4'b0001 << ((n - 2) % 3));
    cfg(0, 2);
    cfg(1, 2);
    cfg(2, 2);
    run(5);
    chk("contend no overrun yet", bus.overrun, 4'b0000);
    run(6);
    chk("contend overrun", bus.overrun, 4'b0111);
    bus.overrun_clr = 1'b1;
    run(1);
    bus.overrun_clr = 1'b0;
    chk("clr vs set", bus.overrun, 4'b0001);
    chk("contend sb empty", sb.size(), 0);
    do_reset();
    base = cyc + 1;
    cfg(1, 10);
    run(7);
    push(base + 11, 4'b0010);
    push(base + 14, 4'b0010);
    cfg(1, 3);
    run(8);
    push(base + 20, 4'b0010);
    cfg(1, 3);
    run(4);
    chk("reconf sb empty", sb.size(), 0);
    chk("reconf overrun", bus.overrun, 4'b0);
    do_reset();
    cfg5(3, 2);
    for (int j = 0; j < 60; j++) begin
      run(1);
      if (b5.tick[3]) t5.push_back(cyc);
      chk("tick5 other bits", b5.tick[2:0], 3'b0);
    end
    chk("tick5 count", t5.size() >= 5, 1'b1);
    for (int i = 1; i < t5.size(); i++) chk("tick5 period", t5[i] - t5[i - 1], 10);
    cfg5(3, 0);
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      run(1);
      if (b5.tick != 4'b0) cnt++;
    end
    chk("tick5 disabled", cnt, 0);
    chk("tick5 overrun", b5.overrun, 4'b0);
`ifdef TICK_SCHED_SQUARE_EN
    do_reset();
    base = cyc + 1;
    push(base + 6, 4'b0001);
    push(base + 12, 4'b0001);
    cfg(0, 6);
    chk("sq6", bus.clock_out[0], 1'b1);
    for (int n = 1; n <= 17; n++) begin
      run(1);
      chk("sq6", bus.clock_out[0], (n % 6) < 3);
    end
    base = cyc + 1;
    push(base + 5, 4'b0001);
    push(base + 10, 4'b0001);
    cfg(0, 5);
    chk("sq5", bus.clock_out[0], 1'b1);
    for (int n = 1; n <= 14; n++) begin
      run(1);
      chk("sq5", bus.clock_out[0], (n % 5) < 2);
    end
    chk("sq other bits", bus.clock_out[3:1], 3'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
